// File: rtl/mem_arb_defs_pkg.sv
// Shared definitions for the memory arbiter: state codes, port tags and the
// burst counter width helper.
package mem_arb_defs;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_A = 2'd1,
    ARB_OWN_B = 2'd2
  } arb_state_e;

  localparam logic TAG_A = 1'b0;
  localparam logic TAG_B = 1'b1;

  function automatic int burst_cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner / next-state / burst-count logic for mem_arbiter.
// Build option MEM_ARB_RR_EN selects strict round-robin on contested cycles.
module mem_arb_select
  import mem_arb_defs::*;
`ifndef MEM_ARB_RR_EN
#(
  parameter int MAX_BURST = 4,
  parameter int CW        = burst_cnt_w(MAX_BURST)
)
`endif
(
  input  arb_state_e     state,
`ifndef MEM_ARB_RR_EN
  input  logic [CW-1:0]  cnt,
  output logic [CW-1:0]  cnt_next,
`endif
  input  logic           a_req,
  input  logic           b_req,
  output logic           grant_a,
  output logic           grant_b,
  output arb_state_e     state_next
);

`ifndef MEM_ARB_RR_EN
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
  logic [CW-1:0] cnt_inc;

  // Saturating re-grant count; it only matters while the other port waits.
  assign cnt_inc = (cnt == MAX_CNT) ? cnt : cnt + CW'(1);
`endif

  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = ARB_IDLE;
`ifndef MEM_ARB_RR_EN
    cnt_next   = '0;
`endif
    if (a_req && !b_req) begin
      grant_a = 1'b1;
    end else if (b_req && !a_req) begin
      grant_b = 1'b1;
    end else if (a_req && b_req) begin
`ifdef MEM_ARB_RR_EN
      if (state == ARB_OWN_A) grant_b = 1'b1;
      else                    grant_a = 1'b1;
`else
      case (state)
        ARB_OWN_A: if (cnt == MAX_CNT) grant_b = 1'b1; else grant_a = 1'b1;
        ARB_OWN_B: if (cnt == MAX_CNT) grant_a = 1'b1; else grant_b = 1'b1;
        default:   grant_a = 1'b1;
      endcase
`endif
    end

    if (grant_a) begin
      state_next = ARB_OWN_A;
`ifndef MEM_ARB_RR_EN
      cnt_next   = (state == ARB_OWN_A) ? cnt_inc : CW'(1);
`endif
    end else if (grant_b) begin
      state_next = ARB_OWN_B;
`ifndef MEM_ARB_RR_EN
      cnt_next   = (state == ARB_OWN_B) ? cnt_inc : CW'(1);
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_RR_EN for round-robin; default is owner priority with MAX_BURST.
module mem_arbiter
  import mem_arb_defs::*;
#(
  parameter int ADDR_LEN  = 8,
  parameter int WORD_LEN  = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_LEN-1:0] a_addr,
  input  logic [WORD_LEN-1:0] a_wdata,
  output logic                a_ack,
  output logic [WORD_LEN-1:0] a_rdata,
  output logic                a_rvalid,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_LEN-1:0] b_addr,
  input  logic [WORD_LEN-1:0] b_wdata,
  output logic                b_ack,
  output logic [WORD_LEN-1:0] b_rdata,
  output logic                b_rvalid,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic [WORD_LEN-1:0] mem_data_in,
  input  logic [WORD_LEN-1:0] mem_data_out
);

  // Handshake: a requester holds req with a stable command until it sees ack
  // high in the same cycle; that cycle the command is accepted and the
  // requester may change or drop it from the next cycle on. Dropping req
  // before ack withdraws the request with no side effect.

  arb_state_e state, state_next;
  logic       grant_a, grant_b;
  logic       rd_tag, rv_pend, rv_tag;

`ifndef MEM_ARB_RR_EN
  localparam int CW = burst_cnt_w(MAX_BURST);
  logic [CW-1:0] cnt, cnt_next;

  mem_arb_select #(.MAX_BURST(MAX_BURST), .CW(CW)) u_select (
    .state      (state),
    .cnt        (cnt),
    .cnt_next   (cnt_next),
    .a_req      (a_req),
    .b_req      (b_req),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .state_next (state_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else       cnt <= cnt_next;
  end
`else
  mem_arb_select u_select (
    .state      (state),
    .a_req      (a_req),
    .b_req      (b_req),
    .grant_a    (grant_a),
    .grant_b    (grant_b),
    .state_next (state_next)
  );
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ARB_IDLE;
    else       state <= state_next;
  end

  assign a_ack = grant_a & rstn;
  assign b_ack = grant_b & rstn;

  // Command register drives the memory bus one cycle after ack; the read tag
  // travels one stage further so rvalid lines up with mem_data_out.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_r_en    <= 1'b0;
      mem_w_en    <= 1'b0;
      rd_tag      <= TAG_A;
      rv_pend     <= 1'b0;
      rv_tag      <= TAG_A;
    end else begin
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      if (grant_a) begin
        mem_addr    <= a_addr;
        mem_data_in <= a_wdata;
        mem_r_en    <= ~a_we;
        mem_w_en    <= a_we;
        rd_tag      <= TAG_A;
      end else if (grant_b) begin
        mem_addr    <= b_addr;
        mem_data_in <= b_wdata;
        mem_r_en    <= ~b_we;
        mem_w_en    <= b_we;
        rd_tag      <= TAG_B;
      end
      rv_pend <= mem_r_en;
      rv_tag  <= rd_tag;
    end
  end

  assign a_rvalid = rv_pend & (rv_tag == TAG_A);
  assign b_rvalid = rv_pend & (rv_tag == TAG_B);
  assign a_rdata  = mem_data_out;
  assign b_rdata  = mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed + random bench for mem_arbiter with a behavioural memory, a bus
// monitor and per-port read-data scoreboards.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int WW = 8;
  localparam int MB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [WW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ack, b_ack, a_rvalid, b_rvalid, mem_r_en, mem_w_en;
  logic [WW-1:0] a_rdata, b_rdata, mem_data_in;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_data_out = '0;

  mem_arbiter #(.ADDR_LEN(AW), .WORD_LEN(WW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_addr(mem_addr), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // behavioural single-port synchronous memory
  logic [WW-1:0] mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    if (mem_r_en) mem_data_out <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: bus model plus expected read data per port
  logic [WW-1:0] shadow [256] = '{default: '0};
  logic [WW-1:0] exp_a_q[$], exp_b_q[$];
  int            due_a_q[$], due_b_q[$];
  logic          pv = 1'b0, pwe = 1'b0, pport = 1'b0, ea_v, eb_v;
  logic [AW-1:0] paddr = '0, m_addr = '0;
  logic [WW-1:0] pwdata = '0, m_data = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        check("rst_outs", 32'({a_ack, b_ack, a_rvalid, b_rvalid, mem_r_en, mem_w_en,
                                mem_addr, mem_data_in}), 32'(0));
        pv = 1'b0; m_addr = '0; m_data = '0;
        exp_a_q.delete(); exp_b_q.delete(); due_a_q.delete(); due_b_q.delete();
      end else begin
        if (pv) begin m_addr = paddr; m_data = pwdata; end
        check("mem_bus", 32'({mem_r_en, mem_w_en, mem_addr, mem_data_in}),
              32'({pv && !pwe, pv && pwe, m_addr, m_data}));
        if (pv && pwe) shadow[paddr] = pwdata;
        if (pv && !pwe) begin
          if (pport) begin exp_b_q.push_back(shadow[paddr]); due_b_q.push_back(cyc + 1); end
          else       begin exp_a_q.push_back(shadow[paddr]); due_a_q.push_back(cyc + 1); end
        end

        ea_v = (exp_a_q.size() > 0) && (due_a_q[0] == cyc);
        check("a_rvalid", 32'(a_rvalid), 32'(ea_v));
        if (ea_v) begin
          if (a_rvalid) check("a_rdata", 32'(a_rdata), 32'(exp_a_q[0]));
          void'(exp_a_q.pop_front()); void'(due_a_q.pop_front());
        end
        eb_v = (exp_b_q.size() > 0) && (due_b_q[0] == cyc);
        check("b_rvalid", 32'(b_rvalid), 32'(eb_v));
        if (eb_v) begin
          if (b_rvalid) check("b_rdata", 32'(b_rdata), 32'(exp_b_q[0]));
          void'(exp_b_q.pop_front()); void'(due_b_q.pop_front());
        end

        check("ack_any", 32'(a_ack | b_ack), 32'(a_req | b_req));
        check("ack_excl", 32'(a_ack & b_ack), 32'(0));
        pv     = a_ack | b_ack;
        pport  = b_ack;
        pwe    = b_ack ? b_we : a_we;
        paddr  = b_ack ? b_addr : a_addr;
        pwdata = b_ack ? b_wdata : a_wdata;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [WW-1:0] wdata);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [AW-1:0] addr,
                         input logic [WW-1:0] wdata);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
  endtask

  task automatic idle(input int n);
    a_req = 1'b0; b_req = 1'b0;
    repeat (n) step();
  endtask

  task automatic expect_ack(input string tag, input logic ea, input logic eb);
    #2;
    check(tag, 32'({a_ack, b_ack}), 32'({ea, eb}));
  endtask

  logic cont_a;

  initial begin
    // reset, with A requesting to show ack is forced low
    drive_a(1'b1, 1'b0, 8'h01, 8'h00);
    #1 check("rst_init", 32'({a_ack, b_ack, a_rvalid, b_rvalid, mem_r_en, mem_w_en,
                              mem_addr, mem_data_in}), 32'(0));
    a_req = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();

    // A alone: write then read the same address
    drive_a(1'b1, 1'b1, 8'h10, 8'h5A); expect_ack("a_wr_ack", 1'b1, 1'b0); step();
    drive_a(1'b1, 1'b0, 8'h10, 8'h00); expect_ack("a_rd_ack", 1'b1, 1'b0); step();
    a_req = 1'b0;
    #2 check("a_rd_bus", 32'({mem_r_en, mem_w_en, mem_addr}), 32'({2'b10, 8'h10}));
    check("a_rv_early", 32'(a_rvalid), 32'(0));
    step();
    #2 check("a_rv_lat2", 32'({a_rvalid, b_rvalid, a_rdata}), 32'({2'b10, 8'h5A}));
    idle(3);

    // contention from IDLE with both requests held
    drive_a(1'b1, 1'b0, 8'h10, 8'h00);
    drive_b(1'b1, 1'b0, 8'h11, 8'h00);
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_ARB_RR_EN
      cont_a = (i % 2) == 0;
`else
      cont_a = ((i / MB) % 2) == 0;
`endif
      expect_ack($sformatf("contend_%0d", i), cont_a, !cont_a);
      step();
    end
    idle(3);

    // cross-port ordering: A writes, B reads the same address next cycle
    drive_a(1'b1, 1'b1, 8'h20, 8'h33); expect_ack("x_a_wr", 1'b1, 1'b0); step();
    a_req = 1'b0;
    drive_b(1'b1, 1'b0, 8'h20, 8'h00); expect_ack("x_b_rd", 1'b0, 1'b1); step();
    b_req = 1'b0;
    #2 check("x_b_rv_early", 32'(b_rvalid), 32'(0));
    step();
    #2 check("x_b_rv", 32'({b_rvalid, a_rvalid, b_rdata}), 32'({2'b10, 8'h33}));
    idle(3);

    // abort: B pulses req while A owns below the burst limit
    drive_a(1'b1, 1'b0, 8'h10, 8'h00); expect_ack("ab_a0", 1'b1, 1'b0); step();
    drive_b(1'b1, 1'b1, 8'h30, 8'h77);
`ifdef MEM_ARB_RR_EN
    expect_ack("ab_pulse", 1'b0, 1'b1);
`else
    expect_ack("ab_pulse", 1'b1, 1'b0);
`endif
    step();
    b_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_ack($sformatf("ab_a_%0d", i), 1'b1, 1'b0);
      step();
    end
    idle(3);

    // reset during an in-flight read: no rvalid afterwards
    drive_a(1'b1, 1'b0, 8'h10, 8'h00); expect_ack("rr_ack", 1'b1, 1'b0); step();
    #2 check("rr_inflight", 32'(mem_r_en), 32'(1));
    rstn = 1'b0;
    #1 check("rr_async", 32'({a_ack, b_ack, a_rvalid, b_rvalid, mem_r_en, mem_w_en,
                              mem_addr, mem_data_in}), 32'(0));
    step(); step();
    a_req = 1'b0;
    rstn = 1'b1;
    idle(4);

    // reset during a write cycle: the write must not land
    drive_a(1'b1, 1'b1, 8'h40, 8'hEE); expect_ack("rw_ack", 1'b1, 1'b0); step();
    #2 check("rw_inflight", 32'(mem_w_en), 32'(1));
    rstn = 1'b0;
    step();
    a_req = 1'b0;
    rstn = 1'b1;
    step();
    drive_a(1'b1, 1'b0, 8'h40, 8'h00); expect_ack("rw_rd_ack", 1'b1, 1'b0); step();
    a_req = 1'b0;
    step();
    #2 check("rw_rdata", 32'({a_rvalid, a_rdata}), 32'({1'b1, 8'h00}));
    idle(3);

    // random mixed traffic on a small address window
    for (int i = 0; i < 60; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      step();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
